// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int MAX_D_STREAK_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision: data wins unless it has starved a pending fetch too long.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
    parameter int SW           = $clog2(MAX_D_STREAK + 1)
) (
    input  logic          if_req_i,
    input  logic          d_req_i,
    input  logic [SW-1:0] d_streak_i,
    output logic          grant_o,
    output arb_owner_t    owner_o
);

    logic w_d_capped;

    always_comb begin
        w_d_capped = if_req_i && (d_streak_i == SW'(MAX_D_STREAK));
        grant_o    = if_req_i | d_req_i;
        owner_o    = OWN_I;
        if (d_req_i && !w_d_capped) begin
            owner_o = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              if_stall_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              d_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    arb_owner_t        r_owner;
    arb_owner_t        w_owner;
    logic              w_grant;
    logic              w_busy;
    logic [SW-1:0]     r_streak;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .SW           (SW)
    ) u_pick (
        .if_req_i   (if_req_i),
        .d_req_i    (d_req_i),
        .d_streak_i (r_streak),
        .grant_o    (w_grant),
        .owner_o    (w_owner)
    );

    assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next = (w_owner == OWN_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack_i) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_owner     <= OWN_I;
            r_streak    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_grant) begin
                r_owner   <= w_owner;
                r_mem_req <= 1'b1;
                if (w_owner == OWN_D) begin
                    r_mem_addr  <= d_addr_i;
                    r_mem_we    <= d_we_i;
                    r_mem_wdata <= d_wdata_i;
                    // Streak only grows while a fetch is actually waiting.
                    if (!if_req_i) begin
                        r_streak <= '0;
                    end else if (r_streak != SW'(MAX_D_STREAK)) begin
                        r_streak <= r_streak + 1'b1;
                    end
                end else begin
                    r_mem_addr <= if_addr_i;
                    r_mem_we   <= 1'b0;
                    r_streak   <= '0;
                end
            end
            if (w_busy && mem_ack_i) begin
                r_mem_req <= 1'b0;
                if (r_state == BUSY_I) begin
                    r_if_rdata <= mem_rdata_i;
                end else if (!r_mem_we) begin
                    r_d_rdata <= mem_rdata_i;
                end
            end
        end
    end

    assign if_ack_o    = (r_state == RESP) && (r_owner == OWN_I);
    assign d_ack_o     = (r_state == RESP) && (r_owner == OWN_D);
    assign if_stall_o  = if_req_i & ~if_ack_o;
    assign d_stall_o   = d_req_i & ~d_ack_o;
    assign if_rdata_o  = r_if_rdata;
    assign d_rdata_o   = r_d_rdata;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, memory model and ack scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        if_stall_o;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata_o;
    logic        d_ack_o;
    logic        d_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;

    mem_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .if_stall_o  (if_stall_o),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_rdata_o   (d_rdata_o),
        .d_ack_o     (d_ack_o),
        .d_stall_o   (d_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Memory model: acks after lat cycles of mem_req, or manual drive.
    logic [31:0] mem [logic [31:0]];
    bit          auto_mem = 1'b1;
    int          lat = 1;
    int          cnt = 0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;

    always @(negedge clk) begin
        if (!auto_mem) begin
            cnt = 0;
            mem_ack_i = man_ack;
            mem_rdata_i = man_rdata;
        end else if (mem_req_o) begin
            cnt++;
            mem_ack_i = (cnt == lat);
            mem_rdata_i = 32'hFFFF_FFFF;
            if (cnt == lat) begin
                if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                else if (mem.exists(mem_addr_o)) mem_rdata_i = mem[mem_addr_o];
                else mem_rdata_i = 32'h0;
            end
        end else begin
            cnt = 0;
            mem_ack_i = 1'b0;
            mem_rdata_i = 32'hFFFF_FFFF;
        end
    end

    // Scoreboard: expected rdata queued at issue, popped on each ack.
    logic [31:0] q_if[$];
    logic [31:0] q_d[$];
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;
    grant_t g_log[$];
    logic   prev_req = 1'b0;

    always @(negedge clk) begin
        if (if_ack_o) begin
            if (q_if.size() == 0) chk("if_ack_unexpected", 32'd1, 32'd0);
            else chk("if_rdata", if_rdata_o, q_if.pop_front());
        end
        if (d_ack_o) begin
            if (q_d.size() == 0) chk("d_ack_unexpected", 32'd1, 32'd0);
            else chk("d_rdata", d_rdata_o, q_d.pop_front());
        end
        if (mem_req_o && !prev_req) begin
            g_log.push_back('{mem_we_o, mem_addr_o, mem_wdata_o});
        end
        prev_req = mem_req_o;
    end

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lt;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] exp_if_rd = '0;
    logic [31:0] exp_d_rd = '0;

    task automatic run_one(input vec_t v);
        int stall;
        int reqc;
        bit addr_ok;
        bit we_seen;
        bit done;
        stall = 0;
        reqc = 0;
        addr_ok = 1'b1;
        we_seen = 1'b0;
        done = 1'b0;
        lat = v.lt;
        if (v.is_d) q_d.push_back(v.exp_rd);
        else q_if.push_back(v.exp_rd);
        @(posedge clk);
        #1;
        if (v.is_d) begin
            d_we = v.we;
            d_addr = v.addr;
            d_wdata = v.wdata;
            d_req = 1'b1;
        end else begin
            if_addr = v.addr;
            if_req = 1'b1;
        end
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (v.is_d ? d_stall_o : if_stall_o) stall++;
            if (mem_req_o) begin
                reqc++;
                if (mem_addr_o !== v.addr) addr_ok = 1'b0;
                we_seen = mem_we_o;
            end
            if (v.is_d ? d_ack_o : if_ack_o) begin
                done = 1'b1;
                d_req = 1'b0;
                if_req = 1'b0;
            end
        end
        chk("vec_ack_seen", 32'(done), 32'd1);
        chk("vec_stall_cycles", 32'(stall), 32'(v.lt + 1));
        chk("vec_mem_req_cycles", 32'(reqc), 32'(v.lt));
        chk("vec_addr_stable", 32'(addr_ok), 32'd1);
        chk("vec_mem_we", 32'(we_seen), 32'(v.is_d & v.we));
        if (!v.is_d) exp_if_rd = v.exp_rd;
        else if (!v.we) exp_d_rd = v.exp_rd;
    endtask

    task automatic wait_ack(input bit is_d, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (is_d ? d_ack_o : if_ack_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk(is_d ? "d_ack_timeout" : "if_ack_timeout", 32'(ok), 32'd1);
    endtask

    task automatic i_one(input logic [31:0] a, input logic [31:0] e);
        bit ok;
        q_if.push_back(e);
        @(posedge clk);
        #1;
        if_addr = a;
        if_req = 1'b1;
        wait_ack(1'b0, ok);
        if_req = 1'b0;
        exp_if_rd = e;
    endtask

    task automatic d_store(input logic [31:0] a, input logic [31:0] w);
        bit ok;
        q_d.push_back(exp_d_rd);
        @(posedge clk);
        #1;
        d_we = 1'b1;
        d_addr = a;
        d_wdata = w;
        d_req = 1'b1;
        wait_ack(1'b1, ok);
        d_req = 1'b0;
        d_we = 1'b0;
    endtask

    task automatic d_seq(input logic [31:0] base, input int n);
        bit ok;
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            d_we = 1'b0;
            d_addr = base + 32'(4 * k);
            d_req = 1'b1;
            q_d.push_back(32'h4000_0000 + 32'(k));
            wait_ack(1'b1, ok);
            exp_d_rd = 32'h4000_0000 + 32'(k);
        end
        d_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    logic [31:0] fair_exp[7];

    initial begin
        mem[32'h10] = 32'h2002_0005;
        mem[32'h200] = 32'h1234_5678;
        mem[32'h0] = 32'hA5A5_5A5A;
        mem[32'h14] = 32'h1111_0014;
        mem[32'h18] = 32'h1111_0018;
        mem[32'h24] = 32'h2222_0024;
        for (int k = 0; k < 6; k++) mem[32'h400 + 32'(4 * k)] = 32'h4000_0000 + 32'(k);

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 1, 32'h2002_0005};
        vecs[1] = '{1'b1, 1'b0, 32'h200, 32'h0, 5, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h300, 32'hCAFE_F00D, 2, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h300, 32'h0, 1, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 1'b0, 32'h300, 32'h0, 3, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 1'b0, 32'h0, 32'h0, 2, 32'hA5A5_5A5A};
        vecs[6] = '{1'b1, 1'b1, 32'h8, 32'h0BAD_F00D, 1, 32'hA5A5_5A5A};

        fair_exp = '{32'h400, 32'h404, 32'h408, 32'h40C,
                     32'h18, 32'h410, 32'h414};

        rst = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'd0);
        chk("rst_d_rdata", d_rdata_o, 32'd0);
        chk("rst_acks", {30'd0, if_ack_o, d_ack_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            run_one(vecs[i]);
            idle(1);
        end

        // Simultaneous fetch and store: store must win the first grant.
        lat = 1;
        g_log.delete();
        idle(2);
        fork
            i_one(32'h14, 32'h1111_0014);
            d_store(32'h100, 32'hDEAD_BEEF);
        join
        chk("sim_grants", 32'(g_log.size()), 32'd2);
        if (g_log.size() == 2) begin
            chk("sim_g0_we", 32'(g_log[0].we), 32'd1);
            chk("sim_g0_addr", g_log[0].addr, 32'h100);
            chk("sim_g0_wdata", g_log[0].wdata, 32'hDEAD_BEEF);
            chk("sim_g1_we", 32'(g_log[1].we), 32'd0);
            chk("sim_g1_addr", g_log[1].addr, 32'h14);
        end
        chk("sim_mem_written", mem.exists(32'h100) ? mem[32'h100] : 32'h0,
            32'hDEAD_BEEF);

        // Fairness: a pending fetch gets the 5th grant.
        g_log.delete();
        idle(2);
        fork
            i_one(32'h18, 32'h1111_0018);
            d_seq(32'h400, 6);
        join
        chk("fair_grants", 32'(g_log.size()), 32'd7);
        for (int i = 0; i < 7 && i < g_log.size(); i++) begin
            chk($sformatf("fair_order_%0d", i), g_log[i].addr, fair_exp[i]);
        end

        // Reset mid-fetch, memory ack arriving after reset releases.
        idle(2);
        auto_mem = 1'b0;
        @(posedge clk);
        #1;
        if_addr = 32'h20;
        if_req = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        if_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_if_rd = '0;
        exp_d_rd = '0;
        @(negedge clk);
        chk("rstmid_mem_req", 32'(mem_req_o), 32'd0);
        @(posedge clk);
        #1;
        man_ack = 1'b1;
        man_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_mem_req", 32'(mem_req_o), 32'd0);
            chk("late_ack_if_rdata", if_rdata_o, exp_if_rd);
            chk("late_ack_if_ack", 32'(if_ack_o), 32'd0);
        end
        auto_mem = 1'b1;
        idle(1);
        run_one('{1'b0, 1'b0, 32'h24, 32'h0, 2, 32'h2222_0024});

        // Spurious memory ack while idle.
        idle(2);
        auto_mem = 1'b0;
        @(posedge clk);
        #1;
        man_ack = 1'b1;
        man_rdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("spur_mem_req", 32'(mem_req_o), 32'd0);
            chk("spur_if_rdata", if_rdata_o, exp_if_rd);
            chk("spur_d_rdata", d_rdata_o, exp_d_rd);
            chk("spur_acks", {30'd0, if_ack_o, d_ack_o}, 32'd0);
        end
        auto_mem = 1'b1;
        idle(1);
        run_one('{1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h1234_5678});

        idle(3);
        chk("sb_if_drained", 32'(q_if.size()), 32'd0);
        chk("sb_d_drained", 32'(q_d.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

endmodule
